cpu_sequencer: RTL and testbench
================================

// Module: cpu_sequencer
// PURPOSE
//  Fetch/execute controller for the 8-bit core. Owns the program counter and instruction register,
//  and reads program memory. Feeds the instruction decoder and qualifies its register-file write enable
//  to a single EXEC cycle. Latches ALU status and resolves GOTO and the conditional jumps
//  (IFZ/IFNZ/IFEQ/IFST/IFGT). Supports free-run and single-step.
// PARAMETERS
//  PC_WIDTH          8   program counter / program address width
//  PROGRAM_DataWidth 16  instruction width
//  NumOpCodeBits     5   opcode field width, instruction[15:11]
//  NumStatusBits     2   status width: bit0 = Z (zero), bit1 = C (borrow/less-than)
// PORTS
//  clk             in   1   rising-edge clock
//  rst_n           in   1   asynchronous, active-low reset
//  run             in   1   level; 1 = continuous execution
//  step            in   1   1-cycle pulse; executes exactly one instruction while run=0
//  prog_data       in   16  program memory read data, valid the cycle after prog_rd_en
//  prog_adr        out  8   program memory address (= PC)
//  prog_rd_en      out  1   program memory read strobe
//  instruction     out  16  instruction register, drives the decoder
//  dec_wr_en       in   1   decoder register write request
//  dec_cnt_wr_en   in   1   decoder unconditional jump request (GOTO)
//  literal_adr     in   8   decoder literal / jump target
//  alu_status      in   2   combinational ALU flags for the current instruction
//  reg_wr_en       out  1   qualified register-file write strobe
//  status_q        out  2   latched status flags
//  busy            out  1   1 while an instruction is in flight (FETCH/LOAD/EXEC)
//  illegal         out  1   sticky reserved-opcode flag
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, PC=0, instruction=16'h0000 (NOP).
//   All outputs 0: prog_rd_en, reg_wr_en, status_q, busy, illegal.
//   Reset asserted mid-instruction aborts it; no write strobe or PC update survives.
//  FSM: IDLE -> FETCH -> LOAD -> EXEC -> (FETCH | IDLE). Fixed 3 cycles per instruction.
//   IDLE : busy=0. Go to FETCH if run=1, or if step=1 (while run=0).
//   FETCH: prog_rd_en=1, prog_adr=PC.
//   LOAD : instruction <= prog_data.
//   EXEC : reg_wr_en = dec_wr_en for exactly this one cycle; reg_wr_en is 0 in all other states.
//          Opcode 00001..01000 (ALU op): status_q <= alu_status. Other opcodes leave status_q unchanged.
//          PC update:
//            GOTO (10000), or dec_cnt_wr_en=1  -> PC <= literal_adr
//            IFZ  (10001) taken if status_q[0]=1
//            IFNZ (10010) taken if status_q[0]=0
//            IFEQ (10011) taken if status_q[0]=1
//            IFST (10100) taken if status_q[1]=1
//            IFGT (10101) taken if status_q[1]=0 and status_q[0]=0
//            taken -> PC <= literal_adr; not taken and all other opcodes -> PC <= PC+1
//          Next state: FETCH if run=1, else IDLE.
//  Conditional jumps test status_q as it stood before EXEC, i.e. the flags of the last ALU op.
//  PC increment wraps modulo 2^PC_WIDTH (8'hFF -> 8'h00). A jump target of the current PC is legal (spin loop).
//  Reserved opcodes (01010-01111, 10110-11111): execute as NOP, PC+1, illegal <= 1.
//   illegal is cleared only by reset.
//  step is ignored while run=1 and while busy=1.
//  run falling mid-instruction: the current instruction completes, then the FSM parks in IDLE.
//  prog_adr holds PC in every state.
// TESTING
//  1 Reset: hold rst_n=0 mid-EXEC with dec_wr_en=1 -> reg_wr_en=0 immediately; PC=0, instruction=0, busy=0.
//  2 Free-run, 3 ALU instructions from PC=0 -> prog_adr 0,1,2 every 3 cycles;
//    exactly one reg_wr_en pulse per EXEC.
//  3 ADD yielding alu_status=2'b01, then IFZ with literal 8'h40 -> PC=8'h40.
//    Repeat with 2'b00 -> PC = IFZ address + 1.
//  4 PC=8'hFF executing NOP -> next prog_adr=8'h00; GOTO 8'h10 -> next prog_adr=8'h10.
//  5 run=0; step pulse -> exactly one FETCH/LOAD/EXEC, then IDLE;
//    a second step pulse while busy=1 is ignored.
//  6 Opcode 5'b11000 -> illegal=1, PC+1, no reg_wr_en; illegal stays 1 until rst_n=0.

Source files
------------

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - fetch/execute controller for the 8-bit core
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   run, step         free-run level / single-instruction pulse (honoured only when idle)
//   prog_adr          program memory address, always equal to PC
//   prog_rd_en        program memory read strobe (FETCH)
//   prog_data         program memory read data, valid the cycle after prog_rd_en
//   instruction       instruction register, feeds the decoder
//   dec_wr_en         decoder register-write request
//   dec_cnt_wr_en     decoder unconditional jump request
//   literal_adr       decoder literal / jump target
//   alu_status        combinational ALU flags {C, Z}
//   reg_wr_en         register-file write strobe, EXEC cycle only
//   status_q          latched ALU flags {C, Z}
//   busy              instruction in flight (FETCH/LOAD/EXEC)
//   illegal           sticky reserved-opcode flag, cleared only by reset

module cpu_sequencer #(
    parameter int PC_WIDTH          = 8,
    parameter int PROGRAM_DataWidth = 16,
    parameter int NumOpCodeBits     = 5,
    parameter int NumStatusBits     = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         run,
    input  logic                         step,
    input  logic [PROGRAM_DataWidth-1:0] prog_data,
    output logic [PC_WIDTH-1:0]          prog_adr,
    output logic                         prog_rd_en,
    output logic [PROGRAM_DataWidth-1:0] instruction,
    input  logic                         dec_wr_en,
    input  logic                         dec_cnt_wr_en,
    input  logic [PC_WIDTH-1:0]          literal_adr,
    input  logic [NumStatusBits-1:0]     alu_status,
    output logic                         reg_wr_en,
    output logic [NumStatusBits-1:0]     status_q,
    output logic                         busy,
    output logic                         illegal
);

    typedef logic [NumOpCodeBits-1:0] opcode_t;

    localparam opcode_t OP_ALU_FIRST = opcode_t'(5'b00001);
    localparam opcode_t OP_ALU_LAST  = opcode_t'(5'b01000);
    localparam opcode_t OP_RSV_A_LO  = opcode_t'(5'b01010);
    localparam opcode_t OP_RSV_A_HI  = opcode_t'(5'b01111);
    localparam opcode_t OP_RSV_B_LO  = opcode_t'(5'b10110);
    localparam opcode_t OP_GOTO      = opcode_t'(5'b10000);
    localparam opcode_t OP_IFZ       = opcode_t'(5'b10001);
    localparam opcode_t OP_IFNZ      = opcode_t'(5'b10010);
    localparam opcode_t OP_IFEQ      = opcode_t'(5'b10011);
    localparam opcode_t OP_IFST      = opcode_t'(5'b10100);
    localparam opcode_t OP_IFGT      = opcode_t'(5'b10101);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_EXEC
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] pc_next;
    opcode_t             opcode;
    logic                is_alu;
    logic                is_reserved;
    logic                take_jump;

    assign opcode   = instruction[PROGRAM_DataWidth-1 -: NumOpCodeBits];
    assign prog_adr = pc;

    // Opcode classification; the upper reserved range runs to the top of the field.
    always_comb begin
        is_alu      = (opcode >= OP_ALU_FIRST) && (opcode <= OP_ALU_LAST);
        is_reserved = ((opcode >= OP_RSV_A_LO) && (opcode <= OP_RSV_A_HI))
                   || (opcode >= OP_RSV_B_LO);
    end

    // Conditional jumps look at the flags latched by the previous ALU op,
    // never at the live alu_status.
    always_comb begin
        take_jump = 1'b0;
        if (!is_reserved) begin
            case (opcode)
                OP_GOTO: take_jump = 1'b1;
                OP_IFZ:  take_jump = status_q[0];
                OP_IFNZ: take_jump = !status_q[0];
                OP_IFEQ: take_jump = status_q[0];
                OP_IFST: take_jump = status_q[1];
                OP_IFGT: take_jump = !status_q[1] && !status_q[0];
                default: take_jump = 1'b0;
            endcase
            if (dec_cnt_wr_en) begin
                take_jump = 1'b1;
            end
        end
        pc_next = take_jump ? literal_adr : pc + PC_WIDTH'(1);
    end

    always_comb begin
        state_next = state;
        prog_rd_en = 1'b0;
        reg_wr_en  = 1'b0;
        busy       = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (run || step) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                prog_rd_en = 1'b1;
                state_next = S_LOAD;
            end
            S_LOAD: begin
                state_next = S_EXEC;
            end
            S_EXEC: begin
                // Reserved opcodes behave as NOP, so the decoder's write request is dropped.
                reg_wr_en  = dec_wr_en && !is_reserved;
                state_next = run ? S_FETCH : S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= '0;
            instruction <= '0;
            status_q    <= '0;
            illegal     <= 1'b0;
        end else begin
            if (state == S_LOAD) begin
                instruction <= prog_data;
            end
            if (state == S_EXEC) begin
                pc <= pc_next;
                if (is_alu) begin
                    status_q <= alu_status;
                end
                if (is_reserved) begin
                    illegal <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - self-checking bench for cpu_sequencer

module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        step;
    logic [15:0] prog_data;
    logic [7:0]  prog_adr;
    logic        prog_rd_en;
    logic [15:0] instruction;
    logic        dec_wr_en;
    logic        dec_cnt_wr_en;
    logic [7:0]  literal_adr;
    logic [1:0]  alu_status;
    logic        reg_wr_en;
    logic [1:0]  status_q;
    logic        busy;
    logic        illegal;

    logic [15:0] mem [256];

    int n_tests = 0;
    int n_fail  = 0;

    // ISA-level model state
    logic [7:0] m_pc;
    logic [1:0] m_st;
    logic       m_ill;

    cpu_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
        .step          (step),
        .prog_data     (prog_data),
        .prog_adr      (prog_adr),
        .prog_rd_en    (prog_rd_en),
        .instruction   (instruction),
        .dec_wr_en     (dec_wr_en),
        .dec_cnt_wr_en (dec_cnt_wr_en),
        .literal_adr   (literal_adr),
        .alu_status    (alu_status),
        .reg_wr_en     (reg_wr_en),
        .status_q      (status_q),
        .busy          (busy),
        .illegal       (illegal)
    );

    always #5 clk = ~clk;

    // Synchronous program memory: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (prog_rd_en) prog_data <= mem[prog_adr];
    end

    // Toy decoder: word = {opcode[4:0], wr, status[1:0], literal[7:0]}.
    // Opcode 01001 with bit 9 set drives the jump request directly.
    assign dec_wr_en     = instruction[10];
    assign dec_cnt_wr_en = (instruction[15:11] == 5'd16) ||
                           (instruction[15:11] == 5'd9 && instruction[9]);
    assign literal_adr   = instruction[7:0];
    assign alu_status    = instruction[9:8];

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    function automatic logic [15:0] mk(input logic [4:0] op, input logic wr,
                                       input logic [1:0] st, input logic [7:0] lit);
        return {op, wr, st, lit};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        run   = 1'b0;
        step  = 1'b0;
        rst_n = 1'b0;
        m_pc  = 8'h00;
        m_st  = 2'b00;
        m_ill = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // One instruction at ISA level: returns expected write strobe, advances model.
    task automatic model_exec(input logic [15:0] ins, output logic we);
        int  op;
        bit  rsv;
        bit  jmp;
        op  = int'(ins[15:11]);
        rsv = (op >= 10 && op <= 15) || (op >= 22);
        jmp = 1'b0;
        if (rsv) begin
            we    = 1'b0;
            m_ill = 1'b1;
        end else begin
            we = ins[10];
            case (op)
                16:      jmp = 1'b1;
                9:       jmp = ins[9];
                17, 19:  jmp = m_st[0];
                18:      jmp = !m_st[0];
                20:      jmp = m_st[1];
                21:      jmp = !m_st[1] && !m_st[0];
                default: jmp = 1'b0;
            endcase
        end
        m_pc = jmp ? ins[7:0] : m_pc + 8'd1;
        if (op >= 1 && op <= 8) m_st = ins[9:8];
    endtask

    // Follows one FETCH/LOAD/EXEC under run=1 and compares against the model.
    task automatic run_instr(input bit first);
        logic [15:0] ins;
        logic        we;
        int          k;
        k = 0;
        while (prog_rd_en !== 1'b1 && k < 8) begin
            tick();
            k++;
        end
        check("fetch_seen", prog_rd_en, 1);
        if (!first) check("rhythm_wait", k, 0);
        check("fetch_adr", prog_adr, m_pc);
        check("fetch_no_wr", reg_wr_en, 0);
        ins = mem[m_pc];
        tick();
        check("load_no_wr", reg_wr_en, 0);
        tick();
        model_exec(ins, we);
        check("exec_instr", instruction, ins);
        check("exec_wr", reg_wr_en, we);
        tick();
        check("status_q", status_q, m_st);
        check("illegal", illegal, m_ill);
    endtask

    initial begin
        int rd_cnt;
        int busy_cnt;

        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        do_reset();

        // Reset state
        check("rst_adr", prog_adr, 0);
        check("rst_instr", instruction, 0);
        check("rst_busy", busy, 0);
        check("rst_rd_en", prog_rd_en, 0);
        check("rst_wr", reg_wr_en, 0);
        check("rst_status", status_q, 0);
        check("rst_illegal", illegal, 0);

        // Free-run, three ALU ops
        mem[0] = mk(5'd1, 1'b1, 2'b10, 8'h00);
        mem[1] = mk(5'd2, 1'b1, 2'b00, 8'h00);
        mem[2] = mk(5'd3, 1'b1, 2'b01, 8'h00);
        mem[3] = mk(5'd4, 1'b1, 2'b11, 8'h00);
        run = 1'b1;
        run_instr(1'b1);
        run_instr(1'b0);
        run_instr(1'b0);
        check("free_run_adr3", prog_adr, 8'h03);

        // Reset mid-EXEC while a write is requested
        tick();
        tick();
        check("pre_rst_wr", reg_wr_en, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_wr", reg_wr_en, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_adr", prog_adr, 0);
        check("async_rst_instr", instruction, 0);
        do_reset();

        // IFZ taken on Z=1
        mem[0] = mk(5'd1, 1'b1, 2'b01, 8'h00);
        mem[1] = mk(5'd17, 1'b0, 2'b00, 8'h40);
        run = 1'b1;
        run_instr(1'b1);
        run_instr(1'b0);
        check("ifz_taken_adr", prog_adr, 8'h40);
        do_reset();

        // IFZ not taken on Z=0
        mem[0] = mk(5'd1, 1'b1, 2'b00, 8'h00);
        run = 1'b1;
        run_instr(1'b1);
        run_instr(1'b0);
        check("ifz_not_taken_adr", prog_adr, 8'h02);
        do_reset();

        // PC wrap and GOTO
        mem[1]     = 16'h0000;
        mem[0]     = mk(5'd16, 1'b0, 2'b00, 8'hFF);
        mem[8'hFF] = 16'h0000;
        run = 1'b1;
        run_instr(1'b1);
        run_instr(1'b0);
        check("wrap_adr", prog_adr, 8'h00);
        mem[0] = mk(5'd16, 1'b0, 2'b00, 8'h10);
        run_instr(1'b0);
        check("goto_adr", prog_adr, 8'h10);

        // run falls during LOAD: instruction completes, then parks
        tick();
        run = 1'b0;
        tick();
        tick();
        check("runfall_busy", busy, 0);
        check("runfall_adr", prog_adr, 8'h11);
        tick();
        tick();
        check("runfall_parked", prog_rd_en, 0);
        do_reset();

        // Single step, second pulse while busy ignored
        mem[0] = mk(5'd2, 1'b1, 2'b10, 8'h00);
        step = 1'b1;
        tick();
        step = 1'b0;
        check("step_fetch", prog_rd_en, 1);
        check("step_busy", busy, 1);
        tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        check("step_exec_wr", reg_wr_en, 1);
        tick();
        check("step_idle", busy, 0);
        check("step_adr", prog_adr, 8'h01);
        check("step_status", status_q, 2'b10);
        rd_cnt   = 0;
        busy_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            rd_cnt   += int'(prog_rd_en);
            busy_cnt += int'(busy);
            tick();
        end
        check("step_no_refetch", rd_cnt, 0);
        check("step_stays_idle", busy_cnt, 0);
        do_reset();

        // Reserved opcode: NOP, PC+1, no write, sticky flag
        mem[0] = mk(5'b11000, 1'b1, 2'b11, 8'h33);
        mem[1] = mk(5'd3, 1'b1, 2'b01, 8'h00);
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        tick();
        check("rsv_no_wr", reg_wr_en, 0);
        tick();
        check("rsv_illegal", illegal, 1);
        check("rsv_adr", prog_adr, 8'h01);
        check("rsv_status_kept", status_q, 2'b00);
        m_pc  = 8'h01;
        m_ill = 1'b1;
        run   = 1'b1;
        run_instr(1'b1);
        check("rsv_sticky", illegal, 1);
        do_reset();
        check("rsv_cleared", illegal, 0);

        // Random programs against the ISA model
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        run = 1'b1;
        run_instr(1'b1);
        for (int i = 0; i < 150; i++) run_instr(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
